// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared definitions for the memory access stage: control-word bit
//            positions, access-size encodings, bubble word, FSM states and
//            small lane helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Control word bit positions
  localparam int c_bit_bubble   = 0;
  localparam int c_bit_memread  = 1;
  localparam int c_bit_memwrite = 2;
  localparam int c_bit_regwrite = 3;
  localparam int c_bit_memtoreg = 4;
  localparam int c_bit_size_lo  = 5;
  localparam int c_bit_size_hi  = 6;

  // Control word that marks an empty pipeline slot
  localparam logic [6:0] c_bubble = 7'b0000001;

  // Access size encoding; 2'b11 behaves like a word access
  typedef enum logic [1:0] {
    SIZE_WORD     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_BYTE     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Half accesses need an even address, word accesses a multiple of four
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: is_misaligned = lo[0];
      SIZE_BYTE: is_misaligned = 1'b0;
      default:   is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  // Little-endian byte lanes touched by the access
  function automatic logic [3:0] byte_enable(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: byte_enable = 4'b0001 << lo;
      SIZE_HALF: byte_enable = lo[1] ? 4'b1100 : 4'b0011;
      default:   byte_enable = 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every lane carries it; byte enables pick
  function automatic logic [31:0] store_data(input size_e size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: store_data = {4{data[7:0]}};
      SIZE_HALF: store_data = {2{data[15:0]}};
      default:   store_data = data;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Selects the addressed lane of a 32-bit read word and sign-extends
//            byte and half loads to 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lo_i,
  input  size_e       size_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select and sign extension
  always_comb begin
    w_byte = rdata_i[7:0];
    case (lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SIZE_BYTE: data_o = {{24{w_byte[7]}}, w_byte};
      SIZE_HALF: data_o = {{16{w_half[15]}}, w_half};
      default:   data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM pipeline stage. Issues one data-memory request per load or
//            store, stalls earlier stages until acknowledged, aligns load data
//            and registers the MEM/WB contents. Misaligned accesses are dropped
//            and flagged with a one-cycle exception pulse.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  control_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] sw_in,
  input  logic [4:0]  regdst_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [6:0]  control_out,
  output logic [31:0] alu_out,
  output logic [31:0] ld_out,
  output logic [4:0]  regdst_out,
  output logic        exc_misalign
);

  state_e      state_q, state_d;

  // Request captured on entry to ACCESS so the bus stays stable while waiting
  logic        we_q;
  logic        load_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  lo_q;
  size_e       size_q;

  // MEM/WB registers
  logic [6:0]  ctrl_q,   ctrl_d;
  logic [31:0] alu_q,    alu_d;
  logic [31:0] ld_q,     ld_d;
  logic [4:0]  rd_q,     rd_d;
  logic        exc_q,    exc_d;

  logic        w_bubble, w_rd, w_wr, w_is_mem, w_misalign, w_mem_go;
  logic        w_access, w_stall;
  size_e       w_size;
  logic [31:0] w_ld_data;

  assign w_bubble   = control_in[c_bit_bubble];
  assign w_rd       = control_in[c_bit_memread];
  assign w_wr       = control_in[c_bit_memwrite];
  assign w_size     = size_e'(control_in[c_bit_size_hi:c_bit_size_lo]);
  assign w_is_mem   = !w_bubble && (w_rd || w_wr);
  assign w_misalign = w_is_mem && is_misaligned(w_size, alu_in[1:0]);
  assign w_mem_go   = w_is_mem && !w_misalign;
  assign w_access   = (state_q == ST_ACCESS);

  load_align u_load_align (
    .rdata_i (dmem_rdata),
    .lo_i    (lo_q),
    .size_i  (size_q),
    .data_o  (w_ld_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, stall and MEM/WB next values; default is a bubble slot
  always_comb begin
    state_d = state_q;
    w_stall = 1'b0;
    ctrl_d  = c_bubble;
    alu_d   = '0;
    ld_d    = '0;
    rd_d    = '0;
    exc_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_mem_go) begin
          state_d = ST_ACCESS;
          w_stall = 1'b1;
        end else if (w_misalign) begin
          exc_d = 1'b1;
        end else begin
          ctrl_d = control_in;
          alu_d  = alu_in;
          rd_d   = regdst_in;
        end
      end
      ST_ACCESS: begin
        if (dmem_ack) begin
          state_d = ST_IDLE;
          ctrl_d  = control_in;
          alu_d   = alu_in;
          rd_d    = regdst_in;
          ld_d    = load_q ? w_ld_data : '0;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the request fields when a legal access is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      size_q  <= SIZE_WORD;
    end else if (!w_access && w_mem_go) begin
      we_q    <= w_wr;
      load_q  <= !w_wr;
      addr_q  <= {alu_in[31:2], 2'b00};
      be_q    <= byte_enable(w_size, alu_in[1:0]);
      wdata_q <= store_data(w_size, sw_in);
      lo_q    <= alu_in[1:0];
      size_q  <= w_size;
    end
  end

  // MEM/WB output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= c_bubble;
      alu_q  <= '0;
      ld_q   <= '0;
      rd_q   <= '0;
      exc_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      alu_q  <= alu_d;
      ld_q   <= ld_d;
      rd_q   <= rd_d;
      exc_q  <= exc_d;
    end
  end

  // Stall is masked while reset is held so a waiting op cannot freeze the pipe
  assign stall        = reset & w_stall;
  assign dmem_req     = w_access;
  assign dmem_we      = w_access & we_q;
  assign dmem_be      = w_access ? be_q : 4'b0000;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign control_out  = ctrl_q;
  assign alu_out      = alu_q;
  assign ld_out       = ld_q;
  assign regdst_out   = rd_q;
  assign exc_misalign = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam logic [6:0] BUB    = 7'b0000001;
  localparam logic [6:0] NOP_RW = 7'b0001000;
  localparam logic [6:0] LB     = 7'b1011010;
  localparam logic [6:0] LH     = 7'b0111010;
  localparam logic [6:0] LW     = 7'b0011010;
  localparam logic [6:0] SB     = 7'b1000100;
  localparam logic [6:0] SH     = 7'b0100100;
  localparam logic [6:0] SW     = 7'b0000100;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  control_in;
  logic [31:0] alu_in, sw_in;
  logic [4:0]  regdst_in;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, dmem_req, dmem_we, exc_misalign;
  logic [31:0] dmem_addr, dmem_wdata, alu_out, ld_out;
  logic [3:0]  dmem_be;
  logic [6:0]  control_out;
  logic [4:0]  regdst_out;

  int n_cmp = 0;
  int n_bad = 0;
  int bursts = 0;
  logic req_prev = 1'b0;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .control_in   (control_in),
    .alu_in       (alu_in),
    .sw_in        (sw_in),
    .regdst_in    (regdst_in),
    .stall        (stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .control_out  (control_out),
    .alu_out      (alu_out),
    .ld_out       (ld_out),
    .regdst_out   (regdst_out),
    .exc_misalign (exc_misalign)
  );

  always #5 clk = ~clk;

  // Count request bursts (rising edges of dmem_req)
  always @(negedge clk) begin
    if (dmem_req && !req_prev) bursts++;
    req_prev = dmem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic [6:0] c, input logic [31:0] a, input logic [31:0] s, input logic [4:0] r);
    control_in = c; alu_in = a; sw_in = s; regdst_in = r;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    drive(LW, 32'h0000_0100, 32'h0, 5'd1);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (control_out !== BUB) begin n_bad++; $display("FAIL rst_ctrl: got %b want %b", control_out, BUB); end
    n_cmp++; if (alu_out !== 32'h0) begin n_bad++; $display("FAIL rst_alu: got %h want 0", alu_out); end
    n_cmp++; if (ld_out !== 32'h0) begin n_bad++; $display("FAIL rst_ld: got %h want 0", ld_out); end
    n_cmp++; if (regdst_out !== 5'd0) begin n_bad++; $display("FAIL rst_rd: got %0d want 0", regdst_out); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", dmem_req); end
    n_cmp++; if (exc_misalign !== 1'b0) begin n_bad++; $display("FAIL rst_exc: got %b want 0", exc_misalign); end
    drive(BUB, 32'h0, 32'h0, 5'd0);
    @(negedge clk) reset = 1'b1;
    step;
  endtask

  task automatic test_nonmem;
    drive(NOP_RW, 32'h1234_5678, 32'h0, 5'd9);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nm_stall_pre: got %b want 0", stall); end
    n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL nm_req: got %b want 0", dmem_req); end
    step;
    n_cmp++; if (alu_out !== 32'h1234_5678) begin n_bad++; $display("FAIL nm_alu: got %h want 12345678", alu_out); end
    n_cmp++; if (regdst_out !== 5'd9) begin n_bad++; $display("FAIL nm_rd: got %0d want 9", regdst_out); end
    n_cmp++; if (control_out !== NOP_RW) begin n_bad++; $display("FAIL nm_ctrl: got %b want %b", control_out, NOP_RW); end
    n_cmp++; if (ld_out !== 32'h0) begin n_bad++; $display("FAIL nm_ld: got %h want 0", ld_out); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL nm_stall_post: got %b want 0", stall); end
    drive(BUB, 32'h0, 32'h0, 5'd0);
    step;
    n_cmp++; if (control_out !== BUB) begin n_bad++; $display("FAIL nm_bubble: got %b want %b", control_out, BUB); end
  endtask

  task automatic test_byte_load;
    int n_st;
    n_st = 0;
    drive(LB, 32'h0000_1003, 32'h0, 5'd5);
    dmem_rdata = 32'h80FF_FFFF; dmem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (stall) n_st++;
      if (c == 0) begin
        n_cmp++; if (dmem_req !== 1'b0) begin n_bad++; $display("FAIL lb_req_idle: got %b want 0", dmem_req); end
      end else begin
        n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_1000 || dmem_be !== 4'b1000 || dmem_we !== 1'b0) begin
          n_bad++; $display("FAIL lb_bus: req=%b addr=%h be=%b we=%b want 1 00001000 1000 0", dmem_req, dmem_addr, dmem_be, dmem_we);
        end
        n_cmp++; if (control_out !== BUB) begin n_bad++; $display("FAIL lb_wait_ctrl: got %b want %b", control_out, BUB); end
      end
      step;
    end
    dmem_ack = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lb_ack_stall: got %b want 0", stall); end
    step;
    dmem_ack = 1'b0;
    n_cmp++; if (n_st !== 4) begin n_bad++; $display("FAIL lb_stall_cycles: got %0d want 4", n_st); end
    n_cmp++; if (ld_out !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h want ffffff80", ld_out); end
    n_cmp++; if (control_out !== LB || alu_out !== 32'h0000_1003 || regdst_out !== 5'd5) begin
      n_bad++; $display("FAIL lb_wb: ctrl=%b alu=%h rd=%0d want %b 00001003 5", control_out, alu_out, regdst_out, LB);
    end
    drive(BUB, 32'h0, 32'h0, 5'd0);
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || dmem_be !== 4'b0000) begin n_bad++; $display("FAIL lb_req_drop: req=%b be=%b want 0 0000", dmem_req, dmem_be); end
    step;
  endtask

  task automatic test_half_store;
    drive(SH, 32'h0000_2002, 32'h0000_BEEF, 5'd0);
    dmem_ack = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_be !== 4'b0000) begin
      n_bad++; $display("FAIL sh_idle: stall=%b req=%b we=%b be=%b want 1 0 0 0000", stall, dmem_req, dmem_we, dmem_be);
    end
    step;
    dmem_ack = 1'b1;
    #1;
    n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF || dmem_addr !== 32'h0000_2000) begin
      n_bad++; $display("FAIL sh_bus: req=%b we=%b be=%b wdata=%h addr=%h want 1 1 1100 beefbeef 00002000", dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr);
    end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sh_ack_stall: got %b want 0", stall); end
    step;
    dmem_ack = 1'b0;
    n_cmp++; if (control_out !== SH || alu_out !== 32'h0000_2002 || ld_out !== 32'h0) begin
      n_bad++; $display("FAIL sh_wb: ctrl=%b alu=%h ld=%h want %b 00002002 0", control_out, alu_out, ld_out, SH);
    end
    drive(BUB, 32'h0, 32'h0, 5'd0);
    step;
  endtask

  task automatic test_misalign;
    drive(LW, 32'h0000_3001, 32'h0, 5'd3);
    #1;
    n_cmp++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin n_bad++; $display("FAIL mis_idle: stall=%b req=%b want 0 0", stall, dmem_req); end
    step;
    n_cmp++; if (exc_misalign !== 1'b1) begin n_bad++; $display("FAIL mis_exc: got %b want 1", exc_misalign); end
    n_cmp++; if (control_out !== BUB || dmem_req !== 1'b0) begin n_bad++; $display("FAIL mis_out: ctrl=%b req=%b want %b 0", control_out, dmem_req, BUB); end
    drive(BUB, 32'h0, 32'h0, 5'd0);
    step;
    n_cmp++; if (exc_misalign !== 1'b0) begin n_bad++; $display("FAIL mis_pulse: got %b want 0", exc_misalign); end
  endtask

  task automatic test_lanes;
    logic [6:0]  v_ctrl  [5];
    logic [31:0] v_addr  [5];
    logic [31:0] v_sw    [5];
    logic [31:0] v_rdata [5];
    logic [3:0]  v_be    [5];
    logic [31:0] v_wdata [5];
    logic [31:0] v_ld    [5];
    v_ctrl[0] = LH; v_addr[0] = 32'h4002; v_sw[0] = 32'h0;          v_rdata[0] = 32'h7FFF_8000; v_be[0] = 4'b1100; v_wdata[0] = 32'h0;          v_ld[0] = 32'h0000_7FFF;
    v_ctrl[1] = LH; v_addr[1] = 32'h4000; v_sw[1] = 32'h0;          v_rdata[1] = 32'h7FFF_8000; v_be[1] = 4'b0011; v_wdata[1] = 32'h0;          v_ld[1] = 32'hFFFF_8000;
    v_ctrl[2] = SB; v_addr[2] = 32'h5001; v_sw[2] = 32'h1234_5678; v_rdata[2] = 32'hFFFF_FFFF; v_be[2] = 4'b0010; v_wdata[2] = 32'h7878_7878; v_ld[2] = 32'h0;
    v_ctrl[3] = LB; v_addr[3] = 32'h5002; v_sw[3] = 32'h0;          v_rdata[3] = 32'h0045_0000; v_be[3] = 4'b0100; v_wdata[3] = 32'h0;          v_ld[3] = 32'h0000_0045;
    v_ctrl[4] = SW; v_addr[4] = 32'h6004; v_sw[4] = 32'hA5A5_5A5A; v_rdata[4] = 32'h0;          v_be[4] = 4'b1111; v_wdata[4] = 32'hA5A5_5A5A; v_ld[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      drive(v_ctrl[i], v_addr[i], v_sw[i], 5'd7);
      dmem_ack = 1'b0;
      step;
      dmem_ack = 1'b1; dmem_rdata = v_rdata[i];
      #1;
      n_cmp++; if (dmem_be !== v_be[i] || dmem_we !== v_ctrl[i][2]) begin
        n_bad++; $display("FAIL lane%0d_be: be=%b we=%b want %b %b", i, dmem_be, dmem_we, v_be[i], v_ctrl[i][2]);
      end
      if (v_ctrl[i][2]) begin
        n_cmp++; if (dmem_wdata !== v_wdata[i]) begin n_bad++; $display("FAIL lane%0d_wdata: got %h want %h", i, dmem_wdata, v_wdata[i]); end
      end
      step;
      dmem_ack = 1'b0;
      n_cmp++; if (ld_out !== v_ld[i]) begin n_bad++; $display("FAIL lane%0d_ld: got %h want %h", i, ld_out, v_ld[i]); end
      drive(BUB, 32'h0, 32'h0, 5'd0);
      step;
    end
  endtask

  task automatic test_reset_mid_access;
    int b0;
    drive(LW, 32'h0000_6000, 32'h0, 5'd4);
    dmem_ack = 1'b0;
    step;
    n_cmp++; if (dmem_req !== 1'b1 || stall !== 1'b1) begin n_bad++; $display("FAIL rma_pre: req=%b stall=%b want 1 1", dmem_req, stall); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rma_drop: req=%b stall=%b want 0 0", dmem_req, stall); end
    n_cmp++; if (control_out !== BUB || alu_out !== 32'h0 || ld_out !== 32'h0 || regdst_out !== 5'd0 || exc_misalign !== 1'b0) begin
      n_bad++; $display("FAIL rma_outs: ctrl=%b alu=%h ld=%h rd=%0d exc=%b want reset values", control_out, alu_out, ld_out, regdst_out, exc_misalign);
    end
    drive(BUB, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    b0 = bursts;
    for (int c = 0; c < 3; c++) begin
      step;
      n_cmp++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rma_after%0d: req=%b stall=%b want 0 0", c, dmem_req, stall); end
    end
    dmem_ack = 1'b0;
    step;
    n_cmp++; if (bursts !== b0) begin n_bad++; $display("FAIL rma_retry: bursts=%0d want %0d", bursts, b0); end
  endtask

  task automatic test_back_to_back;
    int b0;
    b0 = bursts;
    drive(SW, 32'h0000_7000, 32'hCAFE_F00D, 5'd0);
    dmem_ack = 1'b0;
    step;
    dmem_ack = 1'b1;
    #1;
    n_cmp++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'hCAFE_F00D || dmem_addr !== 32'h0000_7000) begin
      n_bad++; $display("FAIL b2b_st_bus: we=%b wdata=%h addr=%h want 1 cafef00d 00007000", dmem_we, dmem_wdata, dmem_addr);
    end
    step;
    n_cmp++; if (control_out !== SW) begin n_bad++; $display("FAIL b2b_st_done: got %b want %b", control_out, SW); end
    drive(LW, 32'h0000_7004, 32'h0, 5'd12);
    dmem_ack = 1'b0; dmem_rdata = 32'h1122_3344;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL b2b_gap: req=%b stall=%b want 0 1", dmem_req, stall); end
    step;
    step;
    step;
    dmem_ack = 1'b1;
    step;
    dmem_ack = 1'b0;
    n_cmp++; if (ld_out !== 32'h1122_3344 || control_out !== LW || alu_out !== 32'h0000_7004 || regdst_out !== 5'd12) begin
      n_bad++; $display("FAIL b2b_ld: ld=%h ctrl=%b alu=%h rd=%0d want 11223344 %b 00007004 12", ld_out, control_out, alu_out, regdst_out, LW);
    end
    drive(BUB, 32'h0, 32'h0, 5'd0);
    step;
    step;
    n_cmp++; if (bursts - b0 !== 2) begin n_bad++; $display("FAIL b2b_bursts: got %0d want 2", bursts - b0); end
  endtask

  initial begin
    test_reset;
    test_nonmem;
    test_byte_load;
    test_half_store;
    test_misalign;
    test_lanes;
    test_reset_mid_access;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports control_in  input  7 / alu_in  input  32 / sw_in  input  32 / regdst_in  input  5  EX/MEM stage contents (control, address/ALU result, store data, destination register).
REQ-004 SHALL have port stall  output  1  hold EX/MEM and earlier stages this cycle.
REQ-005 SHALL have ports dmem_req  output  1 / dmem_we  output  1 / dmem_addr  output  32 (word-aligned) / dmem_be  output  4 / dmem_wdata  output  32 / dmem_ack  input  1 / dmem_rdata  input  32  data-memory handshake.
REQ-006 SHALL have ports control_out  output  7 / alu_out  output  32 / ld_out  output  32 / regdst_out  output  5  registered MEM/WB contents.
REQ-007 SHALL have port exc_misalign  output  1  one-cycle pulse on misaligned access.

Function
REQ-008 SHALL decode control bits: [0] bubble (1 = no-op), [1] memread, [2] memwrite, [3] regwrite, [4] memtoreg, [6:5] size (00 word, 01 half, 10 byte, 11 treated as word).
REQ-009 SHALL treat an input as a memory op when bubble=0 and (memread or memwrite); memread and memwrite both set: memwrite wins.
REQ-010 SHALL have states IDLE and ACCESS.
REQ-011 SHALL, for a non-memory input in IDLE, register control/alu/regdst to outputs next edge (1-cycle latency), ld_out=0, stall=0.
REQ-012 SHALL, for an aligned memory op in IDLE, assert stall combinationally, register bubble to outputs, and enter ACCESS next edge.
REQ-013 SHALL, in ACCESS, hold dmem_req=1 with addr/we/be/wdata constant until dmem_ack=1.
REQ-014 SHALL compute stall = (IDLE and aligned mem op) or (ACCESS and not dmem_ack); ack cycle has stall=0 so EX/MEM advances on the same edge.
REQ-015 SHALL, at the ack edge, register control_in, alu_in, regdst_in and aligned load data to outputs and return to IDLE; minimum memory-op latency 2 cycles.
REQ-016 SHALL drive control_out=7'b0000001 (bubble) on every edge where no instruction completes.
REQ-017 SHALL generate dmem_addr = {alu_in[31:2],2'b00}; little-endian lanes; byte: be = 1<<addr[1:0]; half: be = 0011 or 1100 per addr[1]; word: be = 1111.
REQ-018 SHALL replicate store data: byte {4{sw_in[7:0]}}, half {2{sw_in[15:0]}}, word sw_in.
REQ-019 SHALL extract load lane per addr[1:0]/size and sign-extend byte and half to 32 bits.
REQ-020 SHALL detect misalignment (half with addr[0]=1, word with addr[1:0]!=0) in IDLE: no request, no stall, output bubble, exc_misalign=1 for that edge.
REQ-021 SHALL hold dmem_req=0 in IDLE; dmem_ack outside ACCESS is ignored.
REQ-022 SHALL keep dmem_we=0 and dmem_be=0000 whenever dmem_req=0.

Reset
REQ-023 SHALL, on reset=0 at any time including mid-ACCESS, asynchronously force IDLE, dmem_req=0, stall=0, exc_misalign=0, alu_out=0, ld_out=0, regdst_out=0, control_out=7'b0000001.
REQ-024 SHALL not retry an aborted access after reset release.

Structure
REQ-025 SHALL place control-bit indices, size encodings, bubble constant 7'b0000001 and state encoding in shared package mem_pkg.
REQ-026 SHALL implement lane extraction/sign-extension in combinational sub-module load_align.

Verification
REQ-027 Non-mem op alu_in=0x12345678, regdst 5'd9, regwrite -> next edge alu_out=0x12345678, regdst_out=9, stall never high.
REQ-028 Byte load addr 0x1003, dmem_rdata=0x80FFFFFF, ack after 3 ACCESS cycles -> stall high 4 cycles, be=1000, ld_out=0xFFFFFF80.
REQ-029 Half store addr 0x2002, sw_in=0x0000BEEF, immediate ack -> dmem_we=1, be=1100, wdata=0xBEEFBEEF, 2-cycle latency.
REQ-030 Word load addr 0x3001 -> no dmem_req, exc_misalign pulses once, control_out=7'b0000001.
REQ-031 Reset low during ACCESS with ack pending -> dmem_req and stall drop immediately, outputs at reset values, no request after release.
REQ-032 Back-to-back word store then load, ack delays 0 and 2 -> exactly one dmem_req burst per op, no duplicate issue.
